// File: rtl/truth_table_checker.sv
// Exhaustive-vector response checker: sweeps all input vectors to a combinational
// DUT, samples its output after a settle window and compares against a truth table.
module truth_table_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_y,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic                 first_err_valid,
    output logic [N_IN-1:0]      first_err_vec,
    output logic [2**N_IN-1:0]   observed
);

    localparam int                NV       = 2**N_IN;
    localparam logic [N_IN-1:0]   VEC_LAST = N_IN'(NV - 1);
    localparam logic [3:0]        SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN:0]     ERR_ONE  = (N_IN+1)'(1);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NV-1:0]     r_expected;
    logic [NV-1:0]     r_observed;
    logic [N_IN:0]     r_err_count;
    logic              r_first_valid;
    logic [N_IN-1:0]   r_first_vec;
    logic [N_IN-1:0]   r_vec;
    logic [3:0]        r_cnt;

    logic              w_start_ok;
    logic              w_sample;
    logic              w_mismatch;
    logic              w_last;

    assign w_start_ok = start && (r_state != HOLD);
    assign w_sample   = (r_state == HOLD) && (r_cnt == SETTLE_C);
    assign w_mismatch = dut_y != r_expected[r_vec];
    assign w_last     = (r_vec == VEC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = HOLD;
            HOLD:    if (w_sample && w_last) w_state_nxt = DONE;
            DONE:    if (start) w_state_nxt = HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sweep datapath; vec returns to 0 on the final sample so it reads 0 in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_expected    <= '0;
            r_observed    <= '0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
            r_vec         <= '0;
            r_cnt         <= '0;
        end else if (w_start_ok) begin
            r_expected    <= expected;
            r_observed    <= '0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= '0;
            r_vec         <= '0;
            r_cnt         <= '0;
        end else if (r_state == HOLD) begin
            if (!w_sample) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_observed[r_vec] <= dut_y;
                if (w_mismatch) begin
                    r_err_count <= r_err_count + ERR_ONE;
                    if (!r_first_valid) begin
                        r_first_valid <= 1'b1;
                        r_first_vec   <= r_vec;
                    end
                end
                r_cnt <= '0;
                if (w_last) begin
                    r_vec <= '0;
                end else begin
                    r_vec <= r_vec + N_IN'(1);
                end
            end
        end
    end

    always_comb begin
        busy            = (r_state == HOLD);
        done            = (r_state == DONE);
        pass            = (r_state == DONE) && (r_err_count == '0);
        vec             = r_vec;
        err_count       = r_err_count;
        first_err_valid = r_first_valid;
        first_err_vec   = r_first_vec;
        observed        = r_observed;
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized self-checking bench for truth_table_checker: a default instance
// (SETTLE=1) and a SETTLE=0 instance, both checked against a truth-table model.
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] expected;
    logic       dut_y;
    logic [2:0] vec;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic       first_err_valid;
    logic [2:0] first_err_vec;
    logic [7:0] observed;
    logic [7:0] tt;

    logic       start0;
    logic [7:0] expected0;
    logic       dut_y0;
    logic [2:0] vec0;
    logic       busy0, done0, pass0;
    logic [3:0] err_count0;
    logic       first_err_valid0;
    logic [2:0] first_err_vec0;
    logic [7:0] observed0;
    logic [7:0] tt0;

    // Combinational DUT stand-ins: output is the chosen truth table at the driven vector.
    assign dut_y  = tt[vec];
    assign dut_y0 = tt0[vec0];

    truth_table_checker #(.N_IN(3), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .dut_y(dut_y),
        .vec(vec), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec), .observed(observed)
    );

    truth_table_checker #(.N_IN(3), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected0), .dut_y(dut_y0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
        .first_err_valid(first_err_valid0), .first_err_vec(first_err_vec0), .observed(observed0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int popcount8(input logic [7:0] x);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(x[i]);
        return c;
    endfunction

    function automatic int lowest_set(input logic [7:0] x);
        for (int i = 0; i < 8; i++) if (x[i]) return i;
        return 0;
    endfunction

    // Expected results follow directly from the table difference.
    task automatic check_results(input string tag, input logic d, input logic p,
                                 input logic [3:0] ec, input logic fv, input logic [2:0] fvv,
                                 input logic [7:0] obs, input logic [7:0] t, input logic [7:0] e);
        logic [7:0] diff;
        diff = t ^ e;
        check({tag, "_done"}, d, 1);
        check({tag, "_pass"}, p, (diff == 8'h00) ? 1 : 0);
        check({tag, "_errcnt"}, ec, popcount8(diff));
        check({tag, "_observed"}, obs, t);
        check({tag, "_fvalid"}, fv, (diff != 8'h00) ? 1 : 0);
        check({tag, "_fvec"}, fvv, lowest_set(diff));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"}, vec, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_errcnt"}, err_count, 0);
        check({tag, "_fvalid"}, first_err_valid, 0);
        check({tag, "_fvec"}, first_err_vec, 0);
        check({tag, "_observed"}, observed, 0);
    endtask

    // mode 0: plain sweep; 1: start pulse + expected change mid-sweep; 2: reset at cycle 7
    task automatic run_sweep(input string tag, input logic [7:0] t, input logic [7:0] e, input int mode);
        int n;
        @(negedge clk);
        tt = t; expected = e; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_k"}, busy, 1);
        check({tag, "_done_k"}, done, 0);
        check({tag, "_pass_k"}, pass, 0);
        check({tag, "_vec_k"}, vec, 0);
        n = 0;
        while (n < 64) begin
            if (mode == 1 && n == 3) begin start = 1'b1; expected = 8'h00; end
            if (mode == 1 && n == 4) start = 1'b0;
            if (mode == 2 && n == 6) rst_n = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mode == 2 && n == 7) begin
                check_all_zero({tag, "_midreset"});
                rst_n = 1'b1;
                return;
            end
            if (done) break;
            check({tag, "_vec_step"}, vec, n / 2);
            check({tag, "_busy_step"}, busy, 1);
        end
        check({tag, "_latency"}, n, 16);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_vec_end"}, vec, 0);
        check_results(tag, done, pass, err_count, first_err_valid, first_err_vec, observed, t, e);
    endtask

    task automatic run_sweep0(input string tag, input logic [7:0] t, input logic [7:0] e);
        int n;
        @(negedge clk);
        tt0 = t; expected0 = e; start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        check({tag, "_busy_k"}, busy0, 1);
        check({tag, "_vec_k"}, vec0, 0);
        n = 0;
        while (n < 64) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done0) break;
            check({tag, "_vec_step"}, vec0, n);
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_busy_end"}, busy0, 0);
        check_results(tag, done0, pass0, err_count0, first_err_valid0, first_err_vec0, observed0, t, e);
    endtask

    initial begin
        logic [7:0] rt, re;
        rst_n = 1'b0; start = 1'b1; expected = 8'hE8; tt = 8'hE8;
        start0 = 1'b1; expected0 = 8'hE8; tt0 = 8'hE8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check("reset_busy0", busy0, 0);
        check("reset_done0", done0, 0);
        rst_n = 1'b1; start = 1'b0; start0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_no_sweep", busy, 0);
        check("idle_vec", vec, 0);

        run_sweep("majority", 8'hE8, 8'hE8, 0);
        run_sweep("fault_v5", 8'hC8, 8'hE8, 0);
        run_sweep("all_wrong", 8'h17, 8'hE8, 0);
        run_sweep("disturb", 8'hE8, 8'hE8, 1);
        run_sweep("abort", 8'hC8, 8'hE8, 2);
        run_sweep("after_abort", 8'hE8, 8'hE8, 0);
        run_sweep("restart_done", 8'hE8, 8'hE8, 0);

        for (int i = 0; i < 12; i++) begin
            rt = 8'($urandom);
            re = ($urandom_range(0, 2) == 0) ? rt : 8'($urandom);
            run_sweep($sformatf("rand%0d", i), rt, re, 0);
        end

        run_sweep0("s0_majority", 8'hE8, 8'hE8);
        run_sweep0("s0_fault", 8'hC8, 8'hE8);
        for (int i = 0; i < 4; i++) begin
            rt = 8'($urandom);
            re = 8'($urandom);
            run_sweep0($sformatf("s0_rand%0d", i), rt, re);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Sequential response checker for the lab's combinational gate blocks (SOP, POS and reduced-form implementations of the same function). It is the receiving end of the exhaustive-vector flow. It sweeps every input combination to a DUT and samples the DUT's single-bit output after a settle window. It then compares that output against an expected truth table and reports an error count, the first failing vector and a pass flag. The block sits between the DUT and the board LEDs/display, or in a bench wrapper, so a combinational implementation can be checked in hardware without a `$monitor` printout.

## Interface

- `N_IN`, 3, number of DUT inputs; vectors swept 0 .. 2^N_IN-1 (legal 1..5)
- `SETTLE`, 1, extra cycles each vector is held before sampling (legal 0..15)

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  synchronous, active-low reset
- `start`  input  1  begin a sweep; sampled high in IDLE or DONE
- `expected`  input  2^N_IN  expected output; bit i = required Y for input vector i (MSB of vector = A)
- `dut_y`  input  1  DUT output Y
- `vec`  output  N_IN  input vector driven to DUT ({A,B,C} for N_IN=3)
- `busy`  output  1  sweep in progress
- `done`  output  1  sweep complete; held until next start or reset
- `pass`  output  1  done and zero mismatches
- `err_count`  output  N_IN+1  number of mismatching vectors
- `first_err_valid`  output  1  at least one mismatch recorded
- `first_err_vec`  output  N_IN  lowest vector index that mismatched
- `observed`  output  2^N_IN  captured DUT truth table; bit i = dut_y sampled for vector i

## Operation

- FSM states: IDLE, HOLD, DONE.
- IDLE:
  - `vec`=0, `busy`=0.
  - On `start`=1: latch `expected` into an internal copy, clear `observed`, `err_count` and the first-error registers, set settle counter to 0, `vec`=0, go to HOLD.
- HOLD:
  - `busy`=1.
  - While settle counter < SETTLE, increment the counter.
  - When counter == SETTLE, perform the sample edge:
    - write `dut_y` into `observed[vec]`;
    - if `dut_y` != latched `expected[vec]`, increment `err_count`;
    - if this is the first mismatch, load `first_err_vec`=`vec` and set `first_err_valid`=1.
  - After the sample edge:
    - if `vec` == 2^N_IN-1, go to DONE;
    - otherwise `vec`+1, counter=0, stay in HOLD.
- DONE:
  - `done`=1, `busy`=0, `vec`=0.
  - `pass` = (`err_count`==0).
  - Results hold.
  - `start`=1 restarts exactly as from IDLE. `done` and `pass` drop on that edge.
- `start` while in HOLD is ignored.
- Changes to `expected` during HOLD are ignored; only the copy latched at start is used.
- `vec` never wraps: the sweep ends at 2^N_IN-1.
- `err_count` saturation is not needed. Its width holds the maximum value, 2^N_IN.

## Timing

- Reset (`rst_n`=0 at a rising edge):
  - state IDLE;
  - `vec`=0, `busy`=0, `done`=0, `pass`=0;
  - `err_count`=0, `first_err_valid`=0, `first_err_vec`=0, `observed`=0.
- Reset wins over a simultaneous `start`.
- Reset mid-sweep aborts: outputs take reset values after that edge.
- Start accepted at edge k:
  - `vec`=0 and `busy`=1 from k.
  - Each vector is held SETTLE+1 cycles.
  - `dut_y` is sampled at the last edge of its hold window: vector i at edge k+(i+1)(SETTLE+1).
- Final sample edge k+2^N_IN·(SETTLE+1):
  - registers the last compare;
  - `done`=1, `pass` valid, `busy`=0 after the same edge.
- Start-to-done latency = 2^N_IN·(SETTLE+1) cycles; 16 cycles for the defaults.
- The DUT is combinational and must settle within SETTLE+1 cycles of a `vec` change.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

- Reset: hold `rst_n`=0 for 2 cycles, including one with `start`=1 -> all outputs 0, state IDLE, no sweep begins.
- Matching DUT (defaults): 3-input majority, `expected`=8'hE8, `start` at edge k -> `vec` steps 0..7 every 2 cycles. At k+16: `done`=1, `pass`=1, `err_count`=0, `observed`=8'hE8, `first_err_valid`=0.
- Single fault: same DUT with output inverted only at vector 5, `expected`=8'hE8 -> `err_count`=1, `first_err_vec`=5, `first_err_valid`=1, `pass`=0, `observed`=8'hC8.
- All wrong: `dut_y` = ~majority -> `err_count`=8, `first_err_vec`=0, `observed`=8'h17, `pass`=0.
- Disturbance: after a sweep starts, pulse `start` at cycle 3 and change `expected` to 8'h00 -> results identical to the matching-DUT run. In a second run, drive `rst_n`=0 at cycle 7 -> outputs 0 next edge. Then `start` from DONE -> `done` drops, a fresh sweep runs and completes in 16 cycles.
- SETTLE=0, N_IN=3, matching DUT -> one sample per cycle, `done`=1 exactly 8 cycles after the start edge, `pass`=1.
